dff_en_pre: RTL and testbench

- Edge-triggered storage register with a load enable and a synchronous preset.
- Generic building block for control flags and state bits wherever a settable, holdable bit (or word) is needed.
- Single clock domain. No internal state beyond the stored value.

---
 rtl/dff_en_pre_if.sv | 35 +++
 rtl/dff_en_pre.sv | 54 +++++
 tb/tb_dff_en_pre.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dff_en_pre_if.sv
// dff_en_pre_if: bundles the load/preset controls and the register outputs of one
// dff_en_pre instance.
//
// Optional feature macro: DFF_EN_PRE_QN_EN (adds the inverted output Qn).
//
// Signals:
//   clk  - interface clock (port), shared with the register
//   E    - load enable, active-high
//   D    - data to load, WIDTH bits
//   PRE  - synchronous active-high preset
//   Q    - registered output, WIDTH bits
//   Qn   - inverted registered output, WIDTH bits (only with DFF_EN_PRE_QN_EN)
//
// Modports:
//   master - drives E/D/PRE and observes Q (and Qn)
//   slave  - the register side: consumes E/D/PRE and drives Q (and Qn)
interface dff_en_pre_if #(
    parameter int unsigned WIDTH = 1
) (
    input logic clk
);
    logic             E;
    logic [WIDTH-1:0] D;
    logic             PRE;
    logic [WIDTH-1:0] Q;
`ifdef DFF_EN_PRE_QN_EN
    logic [WIDTH-1:0] Qn;

    modport master (input clk, output E, output D, output PRE, input Q, input Qn);
    modport slave  (input clk, input E, input D, input PRE, output Q, output Qn);
`else
    modport master (input clk, output E, output D, output PRE, input Q);
    modport slave  (input clk, input E, input D, input PRE, output Q);
`endif
endinterface

// File: rtl/dff_en_pre.sv
// dff_en_pre: edge-triggered storage register with load enable and synchronous preset.
//
// Optional feature macro: DFF_EN_PRE_QN_EN
//   defined   - adds output Qn (WIDTH bits), the bitwise inverse of Q, after Q
//   undefined - port list is exactly E, D, clk, PRE, Q
//
// Parameters:
//   WIDTH   - bit width of D and Q
//   PRE_VAL - value loaded into Q on preset; truncated or zero-extended to WIDTH
//
// Ports (positional order is fixed for existing instantiations):
//   E    in   1      load enable, active-high
//   D    in   WIDTH  data loaded when E is high
//   clk  in   1      clock, rising edge
//   PRE  in   1      synchronous active-high preset, takes priority over E
//   Q    out  WIDTH  registered output
//   Qn   out  WIDTH  ~Q (only with DFF_EN_PRE_QN_EN)
//
// Q has no power-on value: it is X until the first preset or enabled load.
module dff_en_pre #(
    parameter int unsigned      WIDTH   = 1,
    // The typed declaration truncates or zero-extends any override to WIDTH.
    parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{1'b1}}
) (
    input  logic             E,
    input  logic [WIDTH-1:0] D,
    input  logic             clk,
    input  logic             PRE,
    output logic [WIDTH-1:0] Q
`ifdef DFF_EN_PRE_QN_EN
    ,
    output logic [WIDTH-1:0] Qn
`endif
);

    logic [WIDTH-1:0] q_q;

    // Preset beats enable; with neither, the register holds. An X on E falls
    // through to the hold branch.
    always_ff @(posedge clk) begin
        if (PRE) begin
            q_q <= PRE_VAL;
        end else if (E) begin
            q_q <= D;
        end
    end

    assign Q = q_q;

`ifdef DFF_EN_PRE_QN_EN
    assign Qn = ~q_q;
`endif

endmodule

// File: tb/tb_dff_en_pre.sv
// tb_dff_en_pre: directed and random stimulus for dff_en_pre with a queue scoreboard.
// Two instances run in lockstep: the default WIDTH=1 register and a 4-bit register
// with a non-trivial preset value, sharing E and PRE.
module tb_dff_en_pre;

    localparam int unsigned W4      = 4;
    localparam logic [3:0]  PRE_VAL4 = 4'b0101;

    logic clk;

    dff_en_pre_if #(.WIDTH(1))  bus1 (.clk(clk));
    dff_en_pre_if #(.WIDTH(W4)) bus4 (.clk(clk));

    dff_en_pre dut1 (
        .E   (bus1.E),
        .D   (bus1.D),
        .clk (clk),
        .PRE (bus1.PRE),
        .Q   (bus1.Q)
`ifdef DFF_EN_PRE_QN_EN
        ,
        .Qn  (bus1.Qn)
`endif
    );

    dff_en_pre #(.WIDTH(W4), .PRE_VAL(PRE_VAL4)) dut4 (
        .E   (bus4.E),
        .D   (bus4.D),
        .clk (clk),
        .PRE (bus4.PRE),
        .Q   (bus4.Q)
`ifdef DFF_EN_PRE_QN_EN
        ,
        .Qn  (bus4.Qn)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state and scoreboard queues.
    logic       m1;
    logic [3:0] m4;
    logic       exp_q1[$];
    logic [3:0] exp_q4[$];

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive inputs, push the model's next value, let one
    // rising edge pass, then pop and compare at the following negedge.
    task automatic step(input logic pre, input logic e, input logic d1, input logic [3:0] d4,
                        input string tag);
        logic       e1;
        logic [3:0] e4;
        logic       e1n;
        bus1.PRE = pre;
        bus1.E   = e;
        bus1.D   = d1;
        bus4.PRE = pre;
        bus4.E   = e;
        bus4.D   = d4;
        if (pre) begin
            m1 = 1'b1;
            m4 = PRE_VAL4;
        end else if (e) begin
            m1 = d1;
            m4 = d4;
        end
        exp_q1.push_back(m1);
        exp_q4.push_back(m4);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q1.size() == 0 || exp_q4.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, observed %0d expected 1", tag, exp_q1.size());
        end else begin
            e1 = exp_q1.pop_front();
            e4 = exp_q4.pop_front();
            check({tag, "_q1"}, {3'b000, bus1.Q}, {3'b000, e1});
            check({tag, "_q4"}, bus4.Q, e4);
`ifdef DFF_EN_PRE_QN_EN
            e1n = ~e1;
            check({tag, "_qn1"}, {3'b000, bus1.Qn}, {3'b000, e1n});
            check({tag, "_qn4"}, bus4.Qn, ~e4);
`else
            e1n = 1'b0;
`endif
        end
    endtask

    // Watchdog: the clock is free-running, so this only fires if the bench stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bus1.PRE = 1'b0;
        bus1.E   = 1'b0;
        bus1.D   = 1'b0;
        bus4.PRE = 1'b0;
        bus4.E   = 1'b0;
        bus4.D   = 4'h0;
        @(negedge clk);

        // Preset, then preset held with enable high: preset must win.
        step(1'b1, 1'b0, 1'b0, 4'h0, "preset");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 4'hA, "pre_prio");

        // Enabled loads.
        step(1'b0, 1'b1, 1'b0, 4'h3, "load0");
        step(1'b0, 1'b1, 1'b1, 4'hC, "load1");
        step(1'b0, 1'b1, 1'b0, 4'h9, "load0b");
        step(1'b0, 1'b1, 1'b1, 4'hE, "load1b");

        // Hold with D toggling, then a load after the hold.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'(i % 2), 4'(i), "hold");
        step(1'b0, 1'b1, 1'b0, 4'h0, "load_after_hold");

        // Preset pulse entirely between edges must not change Q.
        bus1.PRE = 1'b1;
        bus4.PRE = 1'b1;
        #2;
        check("pre_pulse_mid_q1", {3'b000, bus1.Q}, 4'h0);
        check("pre_pulse_mid_q4", bus4.Q, 4'h0);
        bus1.PRE = 1'b0;
        bus4.PRE = 1'b0;
        step(1'b0, 1'b0, 1'b1, 4'hF, "pre_pulse_gone");

        // Preset held across an edge: no effect until that edge.
        bus1.PRE = 1'b1;
        bus4.PRE = 1'b1;
        #4;
        check("pre_not_early_q1", {3'b000, bus1.Q}, 4'h0);
        check("pre_not_early_q4", bus4.Q, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, "pre_edge");

        // First edge after preset release follows the enable/hold rule.
        step(1'b0, 1'b0, 1'b0, 4'h2, "pre_release_hold");

        // Random enable/data with preset low.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 4'($urandom_range(15, 0)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
